// File: rtl/matrix_result_streamer.sv
// Snapshots the multiplier's N x N result matrix on its done pulse and drains it row-major
// over a valid/ready stream. Optional `MATRIX_STREAM_LAST_EN adds an end-of-matrix marker.
module matrix_result_streamer #(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      done,
    input  logic [2*DATA_WIDTH-1:0]   C [0:N-1][0:N-1],
    output logic [2*DATA_WIDTH-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_row,
    output logic [7:0]                out_col,
    output logic                      busy,
    output logic                      overrun
`ifdef MATRIX_STREAM_LAST_EN
    ,
    output logic                      out_last
`endif
);

    localparam int unsigned RW = 2 * DATA_WIDTH;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0] LastIdx = 8'(N - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e          state_q;
    logic [RW-1:0]   snap_q [0:N-1][0:N-1];
    logic [7:0]      row_q;
    logic [7:0]      col_q;
    logic [RW-1:0]   data_q;
    logic            overrun_q;
`ifdef MATRIX_STREAM_LAST_EN
    logic            last_q;
`endif

    logic            xfer;
    logic            at_end;
    logic            capture;
    logic [7:0]      nxt_row;
    logic [7:0]      nxt_col;
    logic [RW-1:0]   nxt_data;

    always_comb begin
        xfer    = (state_q == StStream) && out_ready;
        at_end  = (row_q == LastIdx) && (col_q == LastIdx);
        // A done coinciding with the final transfer chains straight into the next matrix.
        capture = done && ((state_q == StIdle) || (xfer && at_end));
        nxt_col = (col_q == LastIdx) ? 8'd0 : col_q + 8'd1;
        nxt_row = (col_q == LastIdx) ? row_q + 8'd1 : row_q;
        // Only consumed when not at the final element, so the index is always in range.
        nxt_data = snap_q[nxt_row[IW-1:0]][nxt_col[IW-1:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            row_q     <= 8'd0;
            col_q     <= 8'd0;
            data_q    <= '0;
            overrun_q <= 1'b0;
`ifdef MATRIX_STREAM_LAST_EN
            last_q    <= 1'b0;
`endif
            for (int i = 0; i < int'(N); i++) begin
                for (int j = 0; j < int'(N); j++) begin
                    snap_q[i][j] <= '0;
                end
            end
        end else begin
            if (done && !capture) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle, StStream: begin
                    if (capture) begin
                        snap_q  <= C;
                        data_q  <= C[0][0];
                        row_q   <= 8'd0;
                        col_q   <= 8'd0;
                        state_q <= StStream;
`ifdef MATRIX_STREAM_LAST_EN
                        last_q  <= 1'b0;
`endif
                    end else if (xfer) begin
                        if (at_end) begin
                            state_q <= StIdle;
                            row_q   <= 8'd0;
                            col_q   <= 8'd0;
                            data_q  <= snap_q[0][0];
`ifdef MATRIX_STREAM_LAST_EN
                            last_q  <= 1'b0;
`endif
                        end else begin
                            row_q  <= nxt_row;
                            col_q  <= nxt_col;
                            data_q <= nxt_data;
`ifdef MATRIX_STREAM_LAST_EN
                            last_q <= (nxt_row == LastIdx) && (nxt_col == LastIdx);
`endif
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == StStream);
    assign busy      = (state_q == StStream);
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign overrun   = overrun_q;
`ifdef MATRIX_STREAM_LAST_EN
    assign out_last  = last_q;
`endif

endmodule

// File: doc/matrix_result_streamer.md
# matrix_result_streamer

Output-side companion to the matrix multiplier. Captures the N×N result matrix `C` on the multiplier's one-cycle `done` pulse and drains it element by element, row-major, over a valid/ready stream. This lets downstream logic read results without holding the wide parallel `C` bus, and frees the multiplier to start its next job once the snapshot is taken.

## Interface
Parameters:
- `N`, default 4: matrix dimension; legal range 2..255.
- `DATA_WIDTH`, default 8: input element width. The result element width is 2*`DATA_WIDTH` (local, not overridable).

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Assertion takes effect immediately; release is synchronised to `clk` by the integrator.
- `done`, input, 1: capture strobe, taken from the multiplier's `done` output (one-cycle pulse).
- `C`, input, [2*DATA_WIDTH-1:0] [0:N-1][0:N-1]: result matrix. Sampled only on a capture edge.
- `out_data`, output, 2*DATA_WIDTH: current element, equal to snapshot[`out_row`][`out_col`].
- `out_valid`, output, 1: `out_data` holds an element not yet transferred.
- `out_ready`, input, 1: consumer accepts the element.
- `out_row`, output, 8: row index of the current element.
- `out_col`, output, 8: column index of the current element.
- `busy`, output, 1: high while the block is in STREAM.
- `overrun`, output, 1: sticky flag; a `done` pulse was dropped.
- `out_last`, output, 1: present only with `MATRIX_STREAM_LAST_EN` (see Configuration).

## Operation
- States:
  - IDLE: `out_valid`=0, `busy`=0.
  - STREAM: `out_valid`=1, `busy`=1.
- IDLE → STREAM: `done`=1 at an edge.
  - Copies all of `C` into the internal snapshot.
  - Sets `out_row`=`out_col`=0.
- In STREAM, a transfer happens at any edge where `out_valid` and `out_ready` are both 1. On a transfer:
  - `out_col` increments.
  - If `out_col` was N-1, `out_col` wraps to 0 and `out_row` increments.
  - If the transferred element was (N-1, N-1), the state returns to IDLE and the indices return to 0.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_row` and `out_col` hold stable. A transfer is never withdrawn.
- `done`=1 in STREAM on an edge that is not the final transfer:
  - The pulse is ignored; the snapshot is unchanged.
  - `overrun` is set to 1 and stays set until reset.
- `done`=1 on the same edge as the final (N-1, N-1) transfer:
  - The new `C` is captured and the state stays STREAM at (0,0).
  - No overrun is flagged and there is no IDLE bubble.
- `C` changing outside a capture edge has no effect.
- Element values pass through unmodified. There is no width conversion.
- Reset values: state IDLE; `out_valid`=0, `busy`=0, `overrun`=0, `out_row`=0, `out_col`=0, `out_data`=0, `out_last`=0; all snapshot entries 0.
- `reset` asserted mid-stream aborts immediately. The remaining elements are lost.

## Timing
- Capture latency: with `done` sampled high at edge k, `out_valid`=1 with element (0,0) from edge k through at least edge k+1.
- Throughput: one element per cycle while `out_ready` is held at 1.
- Full drain with `out_ready` held at 1: N*N transfer edges. `out_valid` falls after the N*N-th transfer edge, so for N=4 that is 16 cycles.
- Outputs are registered: no combinational path from `out_ready` or `done` to any output.
- `out_data` is a registered mux of the snapshot at the next index, so it is updated on the same edge as the indices.

## Configuration
- `MATRIX_STREAM_LAST_EN` defined:
  - Adds output `out_last`, 1 bit. It is 1 exactly while `out_valid`=1 and the current index is (N-1, N-1).
  - It has a row-end variant semantics: none. Only the final element is marked.
- `MATRIX_STREAM_LAST_EN` undefined:
  - The port and its logic are absent.
  - The consumer detects the end from `out_row`/`out_col` or from `busy` falling.

## Test plan
- Reset test: assert `reset`=0 mid-stream at element (1,2). Required: `out_valid`=0, `busy`=0, `overrun`=0, and indices 0 immediately, with no clock edge needed.
- Basic drain: N=4, C = {{14,38,62,86},{38,126,214,302},{62,214,366,518},{86,302,518,734}}, one `done` pulse, `out_ready`=1. Required: 16 transfers in consecutive cycles in row-major order, (0,0)=14 through (3,3)=734, then `out_valid`=0.
- Backpressure: same matrix, `out_ready` toggled 1,0,0,1,… Required: `out_data` stable while stalled, the same 16 values in order with no duplicates, and `busy` high until the 16th transfer.
- Overrun: a second `done` pulse at element (2,0) while C has changed to all 1s. Required: the stream still delivers the original values, then `overrun`=1 and stays 1 after the return to IDLE.
- Back-to-back: `done` coincides with the (3,3) transfer and the new C is the identity matrix. Required: the next cycle shows (0,0)=1 with `out_valid` continuously 1 and `overrun`=0.
- With `MATRIX_STREAM_LAST_EN`: during the basic drain, `out_last`=1 only alongside element (3,3)=734.
